// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: instruction fetch/issue sequencer for the 9-bit mv/mvi/add/sub
// processor. Owns the program counter. Reads instruction words (and the mvi
// immediate) from program memory. Hands each instruction to the control unit
// with a one-cycle Run pulse, then waits for Done before advancing.
module instr_fetch_seq #(
  parameter int unsigned       ADDR_W   = 7,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [2:0]        OPC_MVI  = 3'd1,
  parameter logic [2:0]        OPC_HALT = 3'd7,
  parameter int unsigned       TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              Start,
  input  logic              Stop,
  input  logic              PcLoad,
  input  logic [ADDR_W-1:0] PcIn,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [8:0]        mem_rdata,
  output logic [8:0]        IR,
  output logic              IR_load,
  output logic [8:0]        DIN,
  output logic              Run,
  input  logic              Done,
  output logic              Busy,
  output logic              Halted,
  output logic              Fault,
  output logic [ADDR_W-1:0] pc
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_ISSUE,
    S_WAIT_DONE,
    S_HALTED,
    S_FAULT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [8:0]        ir_q, ir_d;
  logic [8:0]        din_q, din_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              ir_load_q, ir_load_d;
  logic              run_q, run_d;
  logic              busy_q, busy_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] pc_step;

  // Next-state, datapath and registered-output decode; outputs follow the next state
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    din_d   = din_q;
    cnt_d   = cnt_q;
    pc_step = (ir_q[8:6] == OPC_MVI) ? ADDR_W'(2) : ADDR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (PcLoad) begin
          pc_d = PcIn;
        end else if (Start && !Stop) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q[8:6] == OPC_HALT) begin
          state_d = S_HALTED;
        end else if (ir_q[8:6] == OPC_MVI) begin
          state_d = S_FETCH_IMM;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_FETCH_IMM: begin
        if (mem_ack) begin
          din_d   = mem_rdata;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (Done) begin
          pc_d    = pc_q + pc_step;
          state_d = Stop ? S_IDLE : S_FETCH;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d = S_FAULT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HALTED, S_FAULT: begin
        if (PcLoad) begin
          pc_d    = PcIn;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_rd_d   = (state_d == S_FETCH) || (state_d == S_FETCH_IMM);
    mem_addr_d = '0;
    if (state_d == S_FETCH) begin
      mem_addr_d = pc_d;
    end else if (state_d == S_FETCH_IMM) begin
      mem_addr_d = pc_d + ADDR_W'(1);
    end
    ir_load_d = (state_d == S_DECODE);
    run_d     = (state_d == S_ISSUE);
    busy_d    = !((state_d == S_IDLE) || (state_d == S_HALTED) || (state_d == S_FAULT));
    halted_d  = (state_d == S_HALTED);
    fault_d   = (state_d == S_FAULT);
  end

  // State, datapath and output registers; reset abandons any fetch or instruction at once
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      din_q      <= '0;
      cnt_q      <= '0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      ir_load_q  <= 1'b0;
      run_q      <= 1'b0;
      busy_q     <= 1'b0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      din_q      <= din_d;
      cnt_q      <= cnt_d;
      mem_rd_q   <= mem_rd_d;
      mem_addr_q <= mem_addr_d;
      ir_load_q  <= ir_load_d;
      run_q      <= run_d;
      busy_q     <= busy_d;
      halted_q   <= halted_d;
      fault_q    <= fault_d;
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign IR       = ir_q;
  assign IR_load  = ir_load_q;
  assign DIN      = din_q;
  assign Run      = run_q;
  assign Busy     = busy_q;
  assign Halted   = halted_q;
  assign Fault    = fault_q;
  assign pc       = pc_q;

endmodule
